// File: rtl/digit_scan_ctrl_pkg.sv
// digit_scan_ctrl_pkg: shared constants and the active-low digit pattern helper.
package digit_scan_ctrl_pkg;
  localparam int NDIG = 8;
  localparam int SEL_W = 3;
  localparam logic [NDIG-1:0] AN_OFF = 8'hFF;
  function automatic logic [NDIG-1:0] an_onehot(input logic [SEL_W-1:0] s);
    return ~(NDIG'(1) << s);
  endfunction
endpackage

// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_if: display scan bus.
// master drives en, dig_off, flash; slave (the scan controller) drives sel, an, frame_tick.
interface digit_scan_if;
  import digit_scan_ctrl_pkg::*;
  logic en;
  logic [NDIG-1:0] dig_off;
  logic [NDIG-1:0] flash;
  logic [SEL_W-1:0] sel;
  logic [NDIG-1:0] an;
  logic frame_tick;
  modport master(output en, dig_off, flash, input sel, an, frame_tick);
  modport slave(input en, dig_off, flash, output sel, an, frame_tick);
endinterface

// File: rtl/digit_scan_ctrl_scan_prescaler.sv
// scan_prescaler: per-slot cycle counter 0..DIV-1 with hold and restart.
// Ports: clk, rst (sync active-high), hold_i freezes cnt, restart_i forces cnt to 0,
// slot_end_o marks the last cycle of a slot, in_blank_o says the next cnt is inside the blank window.
module scan_prescaler #(
  parameter int DIV = 1000,
  parameter int BLANK = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  input  logic restart_i,
  output logic slot_end_o,
  output logic in_blank_o
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign slot_end_o = cnt_q == CW'(DIV - 1);
  always_comb begin
    cnt_d = restart_i ? '0 : hold_i ? cnt_q : slot_end_o ? '0 : cnt_q + 1'b1;
    // Look-ahead so the registered an lines up with the cnt it belongs to.
    in_blank_o = cnt_d < CW'(BLANK);
  end
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 8-digit time-multiplexed scan controller with blanking, suppression, flashing and frame pulse.
// Ports: clk, rst (sync active-high), bus (digit_scan_if.slave: en, dig_off, flash in; sel, an, frame_tick out).
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIV = 1000,
  parameter int BLANK = 16,
  parameter int FLASH_FRAMES = 64
) (
  input logic clk,
  input logic rst,
  digit_scan_if.slave bus
);
  localparam int FW = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic phase_q, phase_d;
  logic paused_q;
  logic [NDIG-1:0] an_q, an_d;
  logic ft_q;
  logic slot_end, in_blank, advance, wrap, ftop, dark;
  // A cycle with en=0 marks a pause; the first enabled cycle after it restarts the slot.
  scan_prescaler #(.DIV(DIV), .BLANK(BLANK)) u_pre (
    .clk(clk),
    .rst(rst),
    .hold_i(!bus.en),
    .restart_i(bus.en && paused_q),
    .slot_end_o(slot_end),
    .in_blank_o(in_blank)
  );
  always_comb begin
    advance = bus.en && !paused_q && slot_end;
    wrap = advance && sel_q == SEL_W'(NDIG - 1);
    ftop = fcnt_q == FW'(FLASH_FRAMES - 1);
    sel_d = advance ? sel_q + 1'b1 : sel_q;
    fcnt_d = wrap ? (ftop ? '0 : fcnt_q + 1'b1) : fcnt_q;
    phase_d = phase_q ^ (wrap && ftop);
    // Evaluated on next-state values so the new flash phase hits slot 0 of the new frame.
    dark = in_blank || bus.dig_off[sel_d] || (bus.flash[sel_d] && phase_d);
    an_d = (!bus.en || dark) ? AN_OFF : an_onehot(sel_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      fcnt_q <= '0;
      phase_q <= 1'b0;
      paused_q <= 1'b0;
      an_q <= AN_OFF;
      ft_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      fcnt_q <= fcnt_d;
      phase_q <= phase_d;
      paused_q <= !bus.en;
      an_q <= an_d;
      ft_q <= wrap;
    end
  end
  assign bus.sel = sel_q;
  assign bus.an = an_q;
  assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed scoreboard bench for digit_scan_ctrl (DIV=4, BLANK=1, FLASH_FRAMES=2).
module tb_digit_scan_ctrl;
  typedef struct packed {
    int cyc;
    logic [7:0] tag;
    logic [2:0] sel;
    logic [7:0] an;
    logic ft;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int t = 0;
  logic [7:0] tag = 8'd0;
  logic [7:0] pm = 8'h00;
  logic [7:0] pf = 8'h00;
  exp_t q[$];
  exp_t e;
  digit_scan_if bus();
  digit_scan_ctrl #(.DIV(4), .BLANK(1), .FLASH_FRAMES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc != cyc || bus.sel !== e.sel || bus.an !== e.an || bus.frame_tick !== e.ft) begin
        bad++;
        $display("FAIL test%0d cyc=%0d(exp cyc %0d): got sel=%0d an=%h ft=%b, want sel=%0d an=%h ft=%b",
                 e.tag, cyc, e.cyc, bus.sel, bus.an, bus.frame_tick, e.sel, e.an, e.ft);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic want(input logic [2:0] s, input logic [7:0] a, input logic f);
    q.push_back('{cyc: cyc, tag: tag, sel: s, an: a, ft: f});
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      tick();
      want(3'd0, 8'hFF, 1'b0);
    end
    rst = 1'b0;
    t = 0;
    pm = bus.dig_off;
    pf = bus.flash;
  endtask
  // Expected scan state t cycles after release, using the masks applied in the previous cycle.
  task automatic scan(input int n);
    int slot, c, ph;
    logic [7:0] a;
    repeat (n) begin
      slot = (t / 4) % 8;
      c = t % 4;
      ph = (t / 64) % 2;
      a = 8'h01 << slot;
      a = (c == 0 || pm[slot] || (pf[slot] && ph == 1)) ? 8'hFF : ~a;
      want(3'(slot), a, t > 0 && t % 32 == 0);
      pm = bus.dig_off;
      pf = bus.flash;
      tick();
      t++;
    end
  endtask
  initial begin
    bus.en = 1'b1;
    bus.dig_off = 8'h00;
    bus.flash = 8'h00;
    tag = 8'd1;
    do_reset(3);
    scan(70);
    tag = 8'd3;
    bus.dig_off = 8'h04;
    do_reset(1);
    scan(10);
    bus.dig_off = 8'h00;
    scan(10);
    tag = 8'd4;
    bus.flash = 8'h01;
    do_reset(1);
    scan(214);
    tag = 8'd6;
    do_reset(1);
    scan(8);
    tag = 8'd5;
    bus.flash = 8'h00;
    do_reset(1);
    scan(14);
    bus.en = 1'b0;
    repeat (5) begin
      tick();
      want(3'd3, 8'hFF, 1'b0);
    end
    bus.en = 1'b1;
    tick();
    want(3'd3, 8'hFF, 1'b0);
    repeat (3) begin
      tick();
      want(3'd3, 8'hF7, 1'b0);
    end
    tick();
    t = 16;
    pm = bus.dig_off;
    pf = bus.flash;
    scan(20);
    tick();
    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit display; sits directly upstream of the 8:1 digit mux.
- Drives the mux 3-bit select and, in lock-step, the active-low digit (anode) enables.
- Adds a blanking interval against ghosting, per-digit suppression, per-digit flashing for time-set mode, and a frame pulse.

Parameters:
- DIV, 1000, clk cycles per digit slot; legal range DIV >= 2.
- BLANK, 16, cycles at the start of each slot with all digits off; legal range 1 <= BLANK < DIV.
- FLASH_FRAMES, 64, full scan frames per flash half-period; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable.
- dig_off  input  8  bit k=1 keeps digit k dark.
- flash  input  8  bit k=1 blinks digit k.
- sel  output  3  digit index to the mux select.
- an  output  8  active-low digit enables; bit k drives digit k.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered; no combinational path from inputs to outputs.
- Reset values: sel=0, an=8'hFF, frame_tick=0. Internal state also clears: slot counter cnt=0, frame counter fcnt=0, flash_phase=0.
- rst overrides en and all other inputs. It may be asserted at any point mid-slot; state is reset on the next edge.
- Slot structure: cnt counts 0..DIV-1 within a slot.
  - When cnt=DIV-1 and en=1: cnt goes to 0 and sel goes to sel+1, wrapping 7->0.
- an, as a function of the current registered cnt and sel:
  - cnt < BLANK: an=8'hFF.
  - cnt >= BLANK: an = ~(8'b1 << sel), unless dig_off[sel]=1 or (flash[sel]=1 and flash_phase=1), in which case an=8'hFF.
- sel and an therefore change on the same edge. Every sel change lands inside a blanked cycle.
- dig_off and flash are sampled every cycle. A change takes effect on the next edge, including mid-slot.
- frame_tick: high for exactly the one cycle in which state is sel=0, cnt=0 following the wrap from slot 7. It is not asserted after reset release.
- Flash timing:
  - On each frame wrap, fcnt increments.
  - When fcnt reaches FLASH_FRAMES-1 at a wrap, fcnt goes to 0 and flash_phase toggles.
  - Flash period is 2*FLASH_FRAMES frames; lit phase first after reset.
- en=0:
  - cnt, sel, fcnt and flash_phase hold.
  - an=8'hFF and frame_tick=0 from the next edge.
- en returning to 1:
  - cnt restarts at 0 in the same slot (sel unchanged), so a full BLANK interval precedes relighting.
  - No frame_tick is generated by resume.
- Simultaneous events:
  - Frame wrap and flash toggle happen on the same edge; the new flash_phase applies to slot 0 of the new frame.
  - If en=0 coincides with cnt=DIV-1, en=0 wins: no advance.

Decomposition:
- Shared package:
  - NDIG=8, SEL_W=3.
  - AN_OFF=8'hFF.
  - Helper constant/function for the one-hot active-low digit pattern, reused by the display path.
- One natural sub-module: scan_prescaler. It is the cnt counter with hold and restart controls, and outputs slot_end and in_blank.
- The top contains the sel counter, the frame/flash counters and the an/frame_tick output registers.

Test Plan (DIV=4, BLANK=1, FLASH_FRAMES=2, en=1, masks 0 unless stated):
1. Reset then release: rst=1 for 3 cycles gives sel=0, an=FF, frame_tick=0. After release, the sequence is:
   - cycle 0: sel=0, an=FF; cycles 1-3: an=FE.
   - cycle 4: sel=1, an=FF; cycles 5-7: an=FD.
   - The pattern continues through sel=7 with an=7F.
2. Frame wrap: at cycle 32 after release, sel=0 and frame_tick=1 for exactly one cycle. The next pulse is at cycle 64.
3. Suppression: dig_off=8'h04 means an stays FF for the whole of slot 2 (cycles 8-11), while other digits scan normally. Clearing dig_off in cycle 10 gives an=FB at cycle 11.
4. Flash: flash=8'h01 means digit 0 is lit (FE) in frames 0-1, dark (FF) in frames 2-3, and lit again in frames 4-5. Other digits are unaffected.
5. Enable gap: drop en at slot 3, cnt=2, for 5 cycles.
   - Next edge: an=FF and sel holds at 3.
   - After en=1: one cycle with an=FF (cnt=0), then an=F7 for 3 cycles, then sel=4.
6. Reset mid-operation: assert rst during slot 5 with flash_phase=1. Next edge: sel=0, an=FF, frame_tick=0, flash_phase=0. After release, digit 0 is lit with flash=8'h01.
